fifo_wr_ptr_ctrl: RTL and testbench

- Write-side pointer and flag controller for the asynchronous FIFO; lives entirely in the write clock domain.
- Produces the registered Gray-coded write pointer that feeds the 2-flop pointer synchronizer into the read domain.
- Consumes the read pointer already synchronized into the write domain, and generates the memory write strobe/address, full, almost-full, fill level and overflow status.

---
 rtl/fifo_wr_ptr_ctrl.sv | 83 ++++++++
 tb/tb_fifo_wr_ptr_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer/flag controller for an asynchronous FIFO: binary and Gray
// write pointers, full / almost-full / fill level against the synchronized read pointer.
module fifo_wr_ptr_ctrl #(
    parameter int WIDTH_D = 5,
    parameter int AF_TH   = 28
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    input  logic               wr_en,
    input  logic               wr_ovf_clr,
    input  logic [WIDTH_D:0]   wr_rptr_syn,
    output logic               wr_inc,
    output logic [WIDTH_D-1:0] wr_addr,
    output logic [WIDTH_D:0]   wr_gray,
    output logic               wr_full,
    output logic               wr_almost_full,
    output logic [WIDTH_D:0]   wr_level,
    output logic               wr_overflow
);
    localparam int PW = WIDTH_D + 1;
    localparam logic [WIDTH_D:0] AF_TH_V = PW'(AF_TH);

    logic [WIDTH_D:0] bin_q, bin_d;
    logic [WIDTH_D:0] gray_q, gray_d;
    logic [WIDTH_D:0] level_q, level_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH_D:0] rbin;
    logic [WIDTH_D:0] rptr_full;
    logic [WIDTH_D:0] diff;

    assign wr_inc = wr_en & ~full_q;

    // Gray-to-binary: bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(wr_rptr_syn >> i);
        end
    end

    // Full when our next pointer equals the read pointer one lap ahead (top two Gray bits inverted).
    assign rptr_full = {~wr_rptr_syn[WIDTH_D:WIDTH_D-1], wr_rptr_syn[WIDTH_D-2:0]};

    always_comb begin
        bin_d   = bin_q + {{WIDTH_D{1'b0}}, wr_inc};
        gray_d  = bin_d ^ (bin_d >> 1);
        diff    = bin_d - rbin;
        full_d  = (gray_d == rptr_full);
        level_d = diff;
        af_d    = (diff >= AF_TH_V);
        ovf_d   = ovf_q;
        if (wr_ovf_clr) ovf_d = 1'b0;
        if (wr_en && full_q) ovf_d = 1'b1;
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign wr_addr        = bin_q[WIDTH_D-1:0];
    assign wr_gray        = gray_q;
    assign wr_full        = full_q;
    assign wr_almost_full = af_q;
    assign wr_level       = level_q;
    assign wr_overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl (depth 8, AF_TH 6): occupancy-count reference model,
// directed scenarios plus randomized write/read traffic.
module tb_fifo_wr_ptr_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] rptr = '0;
    logic       inc;
    logic [2:0] addr;
    logic [3:0] gray;
    logic       full;
    logic       af;
    logic [3:0] level;
    logic       ovf;

    fifo_wr_ptr_ctrl #(.WIDTH_D(3), .AF_TH(6)) dut (
        .wr_clk(clk), .wr_rst(rst), .wr_en(en), .wr_ovf_clr(clr),
        .wr_rptr_syn(rptr), .wr_inc(inc), .wr_addr(addr), .wr_gray(gray),
        .wr_full(full), .wr_almost_full(af), .wr_level(level), .wr_overflow(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: counts of accepted writes and of reads, both modulo 16.
    int m_wr = 0;
    int m_rd = 0;
    int m_occ = 0;
    bit m_full = 0;
    bit m_ovf = 0;
    bit exp_inc = 0;

    logic [13:0] dut_vec;
    assign dut_vec = {gray, full, af, level, ovf, addr};

    function automatic logic [3:0] to_gray(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [3:0] w;
        logic [3:0] o;
        w = m_wr[3:0];
        o = m_occ[3:0];
        return {to_gray(m_wr), m_full, (m_occ >= 6), o, m_ovf, w[2:0]};
    endfunction

    // Drive inputs for the coming edge (away from it) and predict the combinational strobe.
    task automatic apply(input bit e, input bit c, input bit r, input int rd);
        @(negedge clk);
        en = e; clr = c; rst = r;
        m_rd = rd % 16;
        rptr = to_gray(m_rd);
        exp_inc = e && !m_full;
        #1;
    endtask

    task automatic tick();
        bit acc;
        @(posedge clk);
        if (rst) begin
            m_wr = 0; m_occ = 0; m_full = 0; m_ovf = 0;
        end else begin
            acc = en && !m_full;
            if (en && m_full) m_ovf = 1;
            else if (clr) m_ovf = 0;
            if (acc) m_wr = (m_wr + 1) % 16;
            m_occ = (m_wr - m_rd + 16) % 16;
            m_full = (m_occ == 8);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 1, 0);
            checks++;
            if (inc !== exp_inc) begin
                failures++; $display("FAIL reset_inc: got %b exp %b", inc, exp_inc);
            end
            tick();
            checks++;
            if (dut_vec !== 14'h0) begin
                failures++; $display("FAIL reset_state: got %h exp %h", dut_vec, 14'h0);
            end
        end
        apply(1, 0, 0, 0);
        tick();
        checks++;
        if (gray !== 4'h1 || addr !== 3'd1 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL first_write: got gray=%h addr=%0d exp gray=1 addr=1", gray, addr);
        end
    endtask

    task automatic test_fill();
        logic [3:0] seq [8] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        apply(0, 0, 1, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 0, 0);
            tick();
            checks++;
            if (gray !== seq[i] || dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL fill_%0d: got %h exp %h (gray exp %h)", i, dut_vec, exp_vec(), seq[i]);
            end
            checks++;
            if (af !== (i >= 5) || full !== (i == 7)) begin
                failures++; $display("FAIL fill_flags_%0d: got af=%b full=%b", i, af, full);
            end
        end
        apply(1, 0, 0, 0);
        checks++;
        if (inc !== 1'b0) begin
            failures++; $display("FAIL full_inc: got %b exp 0", inc);
        end
    endtask

    task automatic test_overflow();
        tick();
        checks++;
        if (ovf !== 1'b1 || gray !== 4'hC || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL ovf_set: got %h exp %h", dut_vec, exp_vec());
        end
        apply(1, 1, 0, 0);
        tick();
        checks++;
        if (ovf !== 1'b1 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL ovf_set_wins: got ovf=%b exp 1", ovf);
        end
        apply(0, 1, 0, 0);
        tick();
        checks++;
        if (ovf !== 1'b0 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL ovf_clr: got ovf=%b exp 0", ovf);
        end
    endtask

    task automatic test_drain_release();
        apply(0, 0, 0, 1);
        tick();
        checks++;
        if (full !== 1'b0 || level !== 4'd7 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL drain: got full=%b level=%0d exp 0/7", full, level);
        end
        apply(1, 0, 0, 1);
        tick();
        checks++;
        if (full !== 1'b1 || gray !== 4'hD || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL refill: got full=%b gray=%h exp 1/D", full, gray);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        apply(0, 0, 0, m_wr + 16 - 2);
        tick();
        for (int i = 0; i < 20; i++) begin
            prev = gray;
            apply(1, 0, 0, m_wr + 16 - 1);
            tick();
            checks++;
            if (level !== 4'd2 || full !== 1'b0 || $countones(prev ^ gray) != 1 || dut_vec !== exp_vec()) begin
                failures++; $display("FAIL wrap_%0d: got %h exp %h prev gray %h", i, dut_vec, exp_vec(), prev);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(0, 0, 1, 0);
        tick();
        for (int i = 0; i < 9; i++) begin
            apply(1, 0, 0, 0);
            tick();
        end
        apply(0, 0, 0, 3);
        tick();
        checks++;
        if (level !== 4'd5 || ovf !== 1'b1 || dut_vec !== exp_vec()) begin
            failures++; $display("FAIL mid_setup: got %h exp %h", dut_vec, exp_vec());
        end
        apply(1, 0, 1, 3);
        tick();
        checks++;
        if (dut_vec !== 14'h0) begin
            failures++; $display("FAIL reset_mid: got %h exp %h", dut_vec, 14'h0);
        end
    endtask

    task automatic test_random();
        int rd;
        bit e;
        apply(0, 0, 1, 0);
        tick();
        for (int i = 0; i < 400; i++) begin
            rd = m_rd;
            if (m_occ > 0 && $urandom_range(0, 9) < 4) rd = m_rd + 1;
            e = ($urandom_range(0, 9) < 7);
            apply(e, ($urandom_range(0, 9) == 0), 0, rd);
            checks++;
            if (inc !== exp_inc) begin
                failures++; $display("FAIL rand_inc_%0d: got %b exp %b", i, inc, exp_inc);
            end
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++; $display("FAIL rand_%0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_drain_release();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
